// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// reset_sequencer_pkg : shared types and width helpers for the reset sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  // cnt only ever counts up to max(HOLD,STEP)-1 before a terminal compare clears it
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int m;
    m = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int num_rst);
    return $clog2(num_rst) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// bit_sync : multi-flop single-bit synchronizer with asynchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic async_reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : holds, waits for clock lock, then releases resets in order
// Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_RST     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int LOCK_STAGE  = 3
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               locked_in,
  input  logic               soft_rst_req,
  output logic [NUM_RST-1:0] rst_out,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IDX_W = idx_width(NUM_RST);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);

  logic locked_s;

  bit_sync #(
    .STAGES (LOCK_STAGE)
  ) u_lock_sync (
    .clk         (clk),
    .async_reset (async_reset),
    .d           (locked_in),
    .q           (locked_s)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               restart;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;

    // Lock loss only restarts once resets have started to release; in HOLD it just gates the exit
    restart = soft_rst_req | (~locked_s & ((state_q == RELEASE) | (state_q == DONE)));

    if (restart) begin
      state_d   = HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = locked_s ? RELEASE : WAIT_LOCK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int i = 0; i < NUM_RST; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rst_out_d[i] = 1'b0;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = DONE;
        end
      endcase
    end

    busy_d = (state_d != DONE);
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer : scoreboard bench for reset_sequencer with default params
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  logic       clk          = 1'b0;
  logic       async_reset  = 1'b1;
  logic       locked_in    = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [3:0] rst_out;
  logic       busy;
  logic       done;

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;

  logic [5:0] exp_q[$];

  reset_sequencer #(
    .NUM_RST     (4),
    .HOLD_CYCLES (16),
    .STEP_CYCLES (8),
    .LOCK_STAGE  (3)
  ) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .locked_in    (locked_in),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  // Expected {rst_out, busy, done} at edge e when RELEASE is entered at edge t
  function automatic logic [5:0] exp_vec(input int e, input int t);
    logic [3:0] r;
    logic       fin;
    for (int i = 0; i < 4; i++) begin
      r[i] = (e < t + 8 * (i + 1));
    end
    fin = (e >= t + 32);
    return {r, ~fin, fin};
  endfunction

  task automatic step(input int t);
    logic [5:0] e;
    exp_q.push_back(exp_vec(edge_n + 1, t));
    @(posedge clk);
    edge_n++;
    #1;
    e = exp_q.pop_front();
    chk("rst_out", rst_out, e[5:2]);
    chk("busy", busy, e[1]);
    chk("done", done, e[0]);
  endtask

  task automatic do_reset(input logic lock);
    @(negedge clk);
    async_reset  = 1'b1;
    locked_in    = lock;
    soft_rst_req = 1'b0;
    #2;
    chk("rst_out_in_reset", rst_out, 4'hF);
    chk("busy_in_reset", busy, 1'b1);
    chk("done_in_reset", done, 1'b0);
    @(negedge clk);
    async_reset = 1'b0;
    edge_n      = 0;
    exp_q.delete();
  endtask

  initial begin
    // Power-up, lock present throughout
    do_reset(1'b1);
    for (int k = 0; k < 52; k++) step(16);

    // Lock first seen high at edge 30, visible after three sync flops
    do_reset(1'b0);
    for (int k = 0; k < 68; k++) begin
      locked_in = (edge_n + 1 >= 30);
      step(33);
    end

    // Lock low for edges 35-36 during RELEASE: restart at edge 38
    do_reset(1'b1);
    for (int k = 0; k < 90; k++) begin
      locked_in = !((edge_n + 1 == 35) || (edge_n + 1 == 36));
      step((edge_n + 1 < 38) ? 16 : 54);
    end
    locked_in = 1'b1;

    // Software restart from DONE, sampled at edge 61
    do_reset(1'b1);
    for (int k = 0; k < 90; k++) begin
      soft_rst_req = (edge_n + 1 == 61);
      step((edge_n + 1 < 61) ? 16 : 77);
    end
    soft_rst_req = 1'b0;

    // Software restart during HOLD, sampled at edge 10
    do_reset(1'b1);
    for (int k = 0; k < 40; k++) begin
      soft_rst_req = (edge_n + 1 == 10);
      step((edge_n + 1 < 10) ? 16 : 26);
    end
    soft_rst_req = 1'b0;

    // Asynchronous reset pulsed between edges mid-RELEASE
    do_reset(1'b1);
    for (int k = 0; k < 28; k++) step(16);
    #2;
    async_reset = 1'b1;
    #1;
    chk("rst_out_async_snap", rst_out, 4'hF);
    chk("busy_async_snap", busy, 1'b1);
    chk("done_async_snap", done, 1'b0);
    #2;
    async_reset = 1'b0;
    edge_n      = 0;
    #1;
    chk("rst_out_after_async", rst_out, 4'hF);
    for (int k = 0; k < 52; k++) step(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
